// File: rtl/game_pkg.sv
// Shared constants and types for the breakout game datapaths.
// Screen geometry, colours and the ball FSM encoding.
package game_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int BALL_SIZE = 2;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_MOVE,
    S_DRAW,
    S_LOST
  } ball_state_t;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       busy;
    logic       lost;
  } pix_out_t;

endpackage

// File: rtl/frame_ticker.sv
// Free-running divider producing one tick pulse per TICK_CYCLES clocks.
// Counting pauses while run is low.
module frame_ticker #(
  parameter int TICK_CYCLES = 3_333_333
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (run) begin
        if (cnt == LAST) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Ball mover: erase, bounce/move, redraw once per tick.
// Drives a registered 2x2 pixel stream and a loss pulse.
module ball_engine
  import game_pkg::*;
#(
  parameter int         TICK_CYCLES = 3_333_333,
  parameter int         PADDLE_Y    = 112,
  parameter int         PADDLE_W    = 16,
  parameter logic [2:0] BALL_COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] paddle_x,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       busy,
  output logic       lost
);

  localparam logic [7:0] BX0   = 8'(SCREEN_W / 2 - 1);
  localparam logic [6:0] BY0   = 7'(SCREEN_H / 2);
  localparam logic [8:0] XMAX  = 9'(SCREEN_W - BALL_SIZE);
  localparam logic [8:0] BS9   = 9'(BALL_SIZE);
  localparam logic [8:0] PY9   = 9'(PADDLE_Y);
  localparam logic [8:0] PW9   = 9'(PADDLE_W - 1);
  localparam logic [8:0] H9    = 9'(SCREEN_H);

  ball_state_t state, state_n;
  logic [1:0]  off, off_n;
  logic [7:0]  bx, bx_n;
  logic [6:0]  by, by_n;
  logic        dx, dx_n;
  logic        dy, dy_n;
  logic        pending, pending_n;
  logic        tick;
  logic        run;
  pix_out_t    out_q, out_n;

  logic [8:0] bx9, by9, px9;
  logic       hit_wall;
  logic       hit_top;
  logic       hit_pad;
  logic       miss;

  assign run = enable && (state != S_LOST);

  frame_ticker #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .tick (tick)
  );

  // 9-bit compares keep paddle_x+15 and bx+1 from wrapping
  assign bx9 = {1'b0, bx};
  assign by9 = {2'b00, by};
  assign px9 = {1'b0, paddle_x};

  assign hit_wall = dx ? (bx9 == XMAX) : (bx9 == 9'd0);
  assign hit_top  = !dy && (by9 == 9'd0);
  assign hit_pad  = dy
                 && (by9 + BS9 == PY9)
                 && (bx9 + 9'd1 >= px9)
                 && (bx9 <= px9 + PW9);
  assign miss     = dy && (by9 + BS9 >= H9) && !hit_pad;

  always_comb begin
    state_n   = state;
    off_n     = off;
    bx_n      = bx;
    by_n      = by;
    dx_n      = dx;
    dy_n      = dy;
    pending_n = pending | tick;
    out_n     = '0;

    unique case (state)
      S_IDLE: begin
        if (pending && enable) begin
          pending_n = 1'b0;
          state_n   = S_ERASE;
        end
      end
      S_ERASE: begin
        off_n = off + 2'd1;
        if (off == 2'd3) state_n = S_MOVE;
      end
      S_MOVE: begin
        state_n = S_DRAW;
        if (hit_wall) dx_n = !dx;
        else          bx_n = dx ? bx + 8'd1 : bx - 8'd1;
        unique case (1'b1)
          hit_top, hit_pad: dy_n = !dy;
          miss:             state_n = S_LOST;
          default:          by_n = dy ? by + 7'd1 : by - 7'd1;
        endcase
      end
      S_DRAW: begin
        off_n = off + 2'd1;
        if (off == 2'd3) state_n = S_IDLE;
      end
      S_LOST: begin
        state_n = S_LOST;
      end
      default: state_n = S_IDLE;
    endcase

    // outputs follow the next state so the pixel stream is fully registered
    out_n.busy = (state_n == S_ERASE)
              || (state_n == S_MOVE)
              || (state_n == S_DRAW);
    out_n.plot = (state_n == S_ERASE) || (state_n == S_DRAW);
    if (out_n.plot) begin
      out_n.x = bx_n + 8'(off_n[0]);
      out_n.y = by_n + 7'(off_n[1]);
    end
    out_n.colour = (state_n == S_DRAW) ? BALL_COLOUR : COL_BLACK;
    out_n.lost   = (state == S_MOVE) && miss;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      off     <= 2'd0;
      bx      <= BX0;
      by      <= BY0;
      dx      <= 1'b1;
      dy      <= 1'b0;
      pending <= 1'b0;
      out_q   <= '0;
    end else begin
      state   <= state_n;
      off     <= off_n;
      bx      <= bx_n;
      by      <= by_n;
      dx      <= dx_n;
      dy      <= dy_n;
      pending <= pending_n;
      out_q   <= out_n;
    end
  end

  assign plot   = out_q.plot;
  assign x      = out_q.x;
  assign y      = out_q.y;
  assign colour = out_q.colour;
  assign busy   = out_q.busy;
  assign lost   = out_q.lost;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine with TICK_CYCLES=16.
// Expected trajectories are worked out by hand from reset.
module tb_ball_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] paddle_x = 8'd0;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       busy;
  logic       lost;

  always #5 clk = ~clk;

  ball_engine #(
    .TICK_CYCLES(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .paddle_x(paddle_x),
    .plot    (plot),
    .x       (x),
    .y       (y),
    .colour  (colour),
    .busy    (busy),
    .lost    (lost)
  );

  int passed = 0;
  int total  = 0;
  int wait_n;
  logic [18:0] sv[10];
  logic        sb[10];
  logic        sl[10];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  function automatic logic [18:0] px(input int xx, input int yy,
                                     input int c, input int p);
    return {xx[7:0], yy[6:0], c[2:0], p[0]};
  endfunction

  // wait for busy, then grab 10 consecutive cycles
  task automatic cap(input bit drop, input int rst_at);
    bit found;
    found  = 1'b0;
    wait_n = 0;
    repeat (64) begin
      if (!found) begin
        @(negedge clk);
        wait_n++;
        if (busy) found = 1'b1;
      end
    end
    chk("seq_start", 32'(found), 32'd1);
    if (drop) enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      sv[i] = {x, y, colour, plot};
      sb[i] = busy;
      sl[i] = lost;
      if (i == rst_at) reset = 1'b1;
    end
  endtask

  task automatic skip(input int n);
    repeat (n) cap(1'b0, -1);
  endtask

  task automatic check_seq(input string tag,
                           input int ox, input int oy,
                           input int nx, input int ny);
    int nb;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_erase"}, 32'(sv[i]),
          32'(px(ox + (i % 2), oy + (i / 2), 0, 1)));
      chk({tag, "_draw"}, 32'(sv[5 + i]),
          32'(px(nx + (i % 2), ny + (i / 2), 7, 1)));
    end
    chk({tag, "_move_plot"}, 32'(sv[4][0]), 32'd0);
    for (int i = 0; i < 10; i++) nb += int'(sb[i]);
    chk({tag, "_busy_len"}, 32'(nb), 32'd9);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    int nl;

    // run 1: paddle at 60, full path to the paddle hit
    reset    = 1'b1;
    enable   = 1'b1;
    paddle_x = 8'd60;
    repeat (3) @(negedge clk);
    chk("reset_out", 32'({plot, x, y, colour, busy, lost}), 32'd0);
    reset = 1'b0;
    cap(1'b0, -1);
    chk("first_latency", 32'(wait_n), 32'd18);
    check_seq("m1", 79, 60, 80, 59);
    skip(59);
    cap(1'b0, -1);
    check_seq("top_bounce", 139, 0, 140, 0);
    cap(1'b0, -1);
    check_seq("top_after", 140, 0, 141, 1);
    skip(17);
    cap(1'b0, -1);
    check_seq("wall", 158, 18, 158, 19);
    cap(1'b0, -1);
    check_seq("wall_after", 158, 19, 157, 20);
    skip(90);
    cap(1'b0, -1);
    check_seq("pad_hit", 67, 110, 66, 110);
    cap(1'b0, -1);
    check_seq("pad_after", 66, 110, 65, 109);

    // run 2: enable low at start, then paddle just missed
    reset    = 1'b1;
    enable   = 1'b0;
    paddle_x = 8'd69;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    np = 0;
    repeat (50) begin
      @(negedge clk);
      np += int'(plot | busy);
    end
    chk("disabled_quiet", 32'(np), 32'd0);
    enable = 1'b1;
    cap(1'b0, -1);
    chk("enable_latency", 32'(wait_n), 32'd18);
    check_seq("m1b", 79, 60, 80, 59);
    skip(170);
    cap(1'b0, -1);
    check_seq("pad_miss", 67, 110, 66, 111);
    skip(7);
    cap(1'b0, -1);
    for (int i = 0; i < 4; i++)
      chk("loss_erase", 32'(sv[i]),
          32'(px(59 + (i % 2), 118 + (i / 2), 0, 1)));
    chk("loss_move_plot", 32'(sv[4][0]), 32'd0);
    chk("loss_busy", 32'({sb[4], sb[5]}), 32'd2);
    chk("lost_pulse", 32'(sl[5]), 32'd1);
    chk("lost_once", 32'(sl[6]), 32'd0);
    chk("loss_no_draw", 32'(sv[5][0]), 32'd0);
    np = 0;
    nl = 0;
    repeat (1600) begin
      @(negedge clk);
      np += int'(plot);
      nl += int'(lost);
    end
    chk("lost_quiet_plot", 32'(np), 32'd0);
    chk("lost_quiet_pulse", 32'(nl), 32'd0);

    // run 3: enable drop mid-erase, paddle edge, reset in draw
    reset    = 1'b1;
    enable   = 1'b1;
    paddle_x = 8'd52;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cap(1'b0, -1);
    cap(1'b1, -1);
    check_seq("en_drop", 80, 59, 81, 58);
    np = 0;
    repeat (40) begin
      @(negedge clk);
      np += int'(busy);
    end
    chk("en_low_idle", 32'(np), 32'd0);
    enable = 1'b1;
    skip(169);
    cap(1'b0, -1);
    check_seq("pad_edge", 67, 110, 66, 110);
    cap(1'b0, 6);
    chk("rst_draw1", 32'(sv[5]), 32'(px(65, 109, 7, 1)));
    chk("rst_out", 32'({sv[7], sb[7], sl[7]}), 32'd0);
    reset = 1'b0;
    cap(1'b0, -1);
    chk("rst_latency", 32'(wait_n), 32'd18);
    check_seq("rst_home", 79, 60, 80, 59);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
# ball_engine

Moves and redraws the 2x2-pixel ball once per game tick: erase at the old position, compute the new position with wall and paddle bounces, then draw at the new position. It runs alongside the brick-drawing datapath under the game controller and drives a `plot`/`x`/`y`/`colour` pixel stream toward the 160x120 VGA adapter. It also raises a loss pulse when the ball passes the paddle row.

## Interface
- `TICK_CYCLES`, default 3_333_333: clock cycles per ball move (15 moves/s at 50 MHz); minimum 16.
- `PADDLE_Y`, default 112: screen row of the paddle's top edge.
- `PADDLE_W`, default 16: paddle width in pixels.
- `BALL_COLOUR`, default 3'b111: colour used when drawing the ball.
- `clk`  in  1: system clock (CLOCK_50 at top level).
- `reset`  in  1: synchronous, active-high reset.
- `enable`  in  1: high while the game loop owns the pixel port; low during initial brick draw.
- `paddle_x`  in  8: left column of the paddle, 0..144.
- `plot`  out  1: pixel write strobe (writeEn).
- `x`  out  8: pixel column, 0..159.
- `y`  out  7: pixel row, 0..119.
- `colour`  out  3: pixel colour.
- `busy`  out  1: high from the first ERASE cycle through the last DRAW cycle.
- `lost`  out  1: one-cycle pulse when the ball leaves through the bottom.

## Operation
- Ball state registers:
  - `bx` (8b), `by` (7b): top-left pixel of the ball.
  - `dx`, `dy`: 1-bit direction flags; 1 means +1, 0 means -1.
  - Reset values: `bx`=79, `by`=60, `dx`=1, `dy`=0.
- Tick counter:
  - Advances only while `enable`=1 and the FSM is not in LOST.
  - Wraps at `TICK_CYCLES`-1 and sets a single `tick_pending` flag.
  - A tick that arrives while `tick_pending` is already set is dropped; ticks do not accumulate.
- FSM states: IDLE, ERASE, MOVE, DRAW, LOST.
  - IDLE: when `tick_pending`=1 and `enable`=1, clear `tick_pending` and go to ERASE.
  - ERASE: four cycles, `plot`=1, `colour`=0. Pixel order, indexed by a 2-bit offset counter: (bx,by), (bx+1,by), (bx,by+1), (bx+1,by+1). Then go to MOVE.
  - MOVE: one cycle, `plot`=0. Apply the bounce rules below, update `bx`/`by`, go to DRAW, or go to LOST on loss.
  - DRAW: four cycles, `plot`=1, `colour`=`BALL_COLOUR`, same pixel order at the new position, then go to IDLE.
  - LOST: `lost` pulses on the entry cycle only. The FSM stays in LOST until `reset`; `plot`=0 throughout.
- Bounce rules in MOVE, using the current `dx`/`dy`:
  - Horizontal: if `dx`=1 and `bx`=158, or `dx`=0 and `bx`=0, flip `dx` and leave `bx` unchanged this move. Otherwise apply `bx`±1.
  - Vertical top: if `dy`=0 and `by`=0, flip `dy` and leave `by` unchanged.
  - Paddle: if `dy`=1, `by`+2 = `PADDLE_Y`, and `bx`+1 ≥ `paddle_x` and `bx` ≤ `paddle_x`+`PADDLE_W`-1, set `dy`=0 and leave `by` unchanged.
  - Loss: if `dy`=1 and `by`+2 ≥ 120, go to LOST. Otherwise apply `by`±1.
  - Corner case: the horizontal and vertical rules are evaluated independently, so both flags may flip in the same MOVE.
- Width rules: all compares are done at 9 bits so `paddle_x`+15 and `bx`+1 cannot wrap.
- `enable` falling mid-sequence: the current ERASE/MOVE/DRAW sequence completes. No new sequence starts until `enable` returns high.

## Timing
- Reset values: `plot`=0, `x`=0, `y`=0, `colour`=0, `busy`=0, `lost`=0. FSM in IDLE, tick counter 0, `tick_pending`=0.
- All outputs are registered.
- Latency:
  - `plot` first rises 1 cycle after the IDLE→ERASE decision.
  - One sequence is 9 cycles: 4 ERASE + 1 MOVE + 4 DRAW.
  - `busy` is high for exactly those 9 cycles.
- `paddle_x` is sampled only in the MOVE cycle.
- Reset mid-sequence: outputs take their reset values on the next edge. The partially erased ball is not redrawn.

## Structure
- Shared package `game_pkg`:
  - `SCREEN_W`=160, `SCREEN_H`=120.
  - `BALL_SIZE`=2.
  - Colour constants `COL_BLACK`, `COL_WHITE`.
  - State encoding enum `ball_state_t`.
- Sub-module `frame_ticker`: parameterised by `TICK_CYCLES`; inputs `clk`, `reset`, `run`; output `tick` (one-cycle pulse).

## Test plan
All scenarios use `TICK_CYCLES`=16.
- Reset, `enable`=1 → first sequence: ERASE plots (79,60),(80,60),(79,61),(80,61) with colour 0. DRAW plots (80,59),(81,59),(80,60),(81,60) with colour 7. `busy` high for 9 cycles.
- Preload via reset plus ticks until `bx`=158 with `dx`=1 → next MOVE keeps `bx`=158 and sets `dx`=0; the following move gives `bx`=157.
- `by`=110, `dy`=1, `bx`=50, `paddle_x`=40 → `dy` flips to 0, `by` stays 110, and the next move gives `by`=109.
- Same as above but `paddle_x`=60 → the ball continues down; at `by`=118 MOVE pulses `lost` once, the FSM enters LOST, and `plot` stays 0 for 100 further ticks.
- `enable` held low for 50 cycles → no `plot` activity and the tick counter frozen. `enable` dropped during ERASE → all 9 cycles still complete.
- Reset asserted in DRAW cycle 2 → `plot`=0 on the next cycle and the ball back at (79,60).
